router_fsm: RTL

- Packet-reception controller for the 1x3 router.
- Sequences each incoming packet: header address decode, first-data load, payload load, FIFO-full stall, parity load and parity check.
- Drives the register block and the synchronizer: detect_add, write_enb_reg, lfd/ld/laf/full state flags, rst_int_reg, busy.
- Tracks the latched destination so that a per-FIFO soft reset or a non-empty destination FIFO is handled cleanly.

---
 rtl/router_fsm.sv | 114 +++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: decodes the header address,
// sequences payload/parity loading and stalls while the addressed FIFO is full.
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty0,
  input  logic       fifo_empty1,
  input  logic       fifo_empty2,
  input  logic       soft_reset0,
  input  logic       soft_reset1,
  input  logic       soft_reset2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;
  logic       hdr_valid;
  logic       hdr_empty;
  logic       emp_sel;
  logic       soft_sel;

  assign hdr_valid = pkt_valid && (data_in != 2'b11);

  // Header decode looks at the incoming address; WTE and soft reset use the latched one.
  always_comb begin
    hdr_empty = 1'b0;
    emp_sel   = 1'b0;
    soft_sel  = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty0;
      2'd1:    hdr_empty = fifo_empty1;
      2'd2:    hdr_empty = fifo_empty2;
      default: hdr_empty = 1'b0;
    endcase
    case (addr)
      2'd0:    begin emp_sel = fifo_empty0; soft_sel = soft_reset0; end
      2'd1:    begin emp_sel = fifo_empty1; soft_sel = soft_reset1; end
      2'd2:    begin emp_sel = fifo_empty2; soft_sel = soft_reset2; end
      default: begin emp_sel = 1'b0;        soft_sel = 1'b0;        end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DA;
      addr  <= 2'b00;
    end else begin
      state <= next_state;
      if (state == DA && hdr_valid) addr <= data_in;
    end
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    if (state != DA && soft_sel) begin
      next_state = DA;
    end else begin
      case (state)
        DA:  if (hdr_valid) next_state = hdr_empty ? LFD : WTE;
        LFD: next_state = LD;
        LD: begin
          if (fifo_full)       next_state = FFS;
          else if (!pkt_valid) next_state = LP;
        end
        FFS: if (!fifo_full) next_state = LAF;
        LAF: begin
          if (parity_done)        next_state = DA;
          else if (low_pkt_valid) next_state = LP;
          else                    next_state = LD;
        end
        LP:  next_state = CPE;
        CPE: next_state = fifo_full ? FFS : DA;
        WTE: if (emp_sel) next_state = LFD;
        default: next_state = DA;
      endcase
    end
  end

  assign detect_add    = (state == DA);
  assign lfd_state     = (state == LFD);
  assign ld_state      = (state == LD);
  assign laf_state     = (state == LAF);
  assign full_state    = (state == FFS);
  assign rst_int_reg   = (state == CPE);
  assign write_enb_reg = (state == LD) || (state == LAF) || (state == LP);
  assign busy          = !((state == DA) || (state == LD));

endmodule
